// File: rtl/atm_account_ctrl.sv
// ATM account controller: card/PIN session FSM over a small bank of account
// balances, with lockout after repeated wrong PINs and per-state idle timeout.
module atm_account_ctrl #(
  parameter int          NUM_ACCT    = 4,
  parameter int          BAL_W       = 32,
  parameter int          PIN_W       = 16,
  parameter int          MAX_TRIES   = 3,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [63:0] BAL_INIT    = 64'd1000000,
  parameter logic [63:0] PIN_INIT    = 64'h000A,
  localparam int         AID_W       = $clog2(NUM_ACCT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             card_in,
  input  logic [AID_W-1:0] acct_id,
  input  logic             lang_valid,
  input  logic             pin_valid,
  input  logic [PIN_W-1:0] pin,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  input  logic             amt_valid,
  input  logic [BAL_W-1:0] amount,
  output logic [3:0]       state,
  output logic [BAL_W-1:0] balance_out,
  output logic             show_balance,
  output logic             dep_ok,
  output logic             dep_err,
  output logic             wd_ok,
  output logic             wd_denied,
  output logic             pin_err,
  output logic             card_ejected,
  output logic             card_retained
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BAL_W-1:0] BAL_RST = BAL_INIT[BAL_W-1:0];
  localparam logic [PIN_W-1:0] PIN_RST = PIN_INIT[PIN_W-1:0];

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LANG   = 4'd1,
    S_PIN    = 4'd2,
    S_MENU   = 4'd3,
    S_DEP    = 4'd4,
    S_WD     = 4'd5,
    S_UPDATE = 4'd6,
    S_SHOW   = 4'd7,
    S_EJECT  = 4'd8,
    S_RETAIN = 4'd9
  } state_t;

  state_t             state_reg;
  logic [BAL_W-1:0]   bal_mem [NUM_ACCT];
  logic [PIN_W-1:0]   pin_mem [NUM_ACCT];
  logic [NUM_ACCT-1:0] lock_reg;
  logic [AID_W-1:0]   acct_reg;
  logic [BAL_W-1:0]   amt_reg;
  logic               is_dep_reg;
  logic [TRY_W-1:0]   tries_reg;
  logic [TMR_W-1:0]   tmr_reg;

  logic [BAL_W-1:0]   balance_out_reg;
  logic show_balance_reg, dep_ok_reg, dep_err_reg, wd_ok_reg, wd_denied_reg;
  logic pin_err_reg, card_ejected_reg, card_retained_reg;

  logic [BAL_W-1:0] sel_bal;
  logic [PIN_W-1:0] sel_pin;
  logic [BAL_W-1:0] upd_bal;
  logic             dep_ovf;
  logic             any_strobe;
  logic             timed;
  logic             card_drop;
  logic             timeout;

  assign sel_bal    = bal_mem[acct_reg];
  assign sel_pin    = pin_mem[acct_reg];
  assign upd_bal    = is_dep_reg ? (sel_bal + amt_reg) : (sel_bal - amt_reg);
  // balance + amount overflows exactly when amount exceeds the headroom ~balance
  assign dep_ovf    = (amount > ~sel_bal);
  assign any_strobe = lang_valid | pin_valid | op_valid | amt_valid;
  assign timed      = (state_reg == S_LANG) || (state_reg == S_PIN) || (state_reg == S_MENU) ||
                      (state_reg == S_DEP)  || (state_reg == S_WD)  || (state_reg == S_SHOW);
  assign card_drop  = !card_in && (state_reg != S_IDLE) && (state_reg != S_EJECT) &&
                      (state_reg != S_RETAIN);
  assign timeout    = timed && !any_strobe && (tmr_reg == TMR_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg         <= S_IDLE;
      lock_reg          <= '0;
      acct_reg          <= '0;
      amt_reg           <= '0;
      is_dep_reg        <= 1'b0;
      tries_reg         <= '0;
      tmr_reg           <= '0;
      balance_out_reg   <= '0;
      show_balance_reg  <= 1'b0;
      dep_ok_reg        <= 1'b0;
      dep_err_reg       <= 1'b0;
      wd_ok_reg         <= 1'b0;
      wd_denied_reg     <= 1'b0;
      pin_err_reg       <= 1'b0;
      card_ejected_reg  <= 1'b0;
      card_retained_reg <= 1'b0;
      for (int i = 0; i < NUM_ACCT; i++) begin
        bal_mem[i] <= BAL_RST;
        pin_mem[i] <= PIN_RST;
      end
    end else begin
      dep_ok_reg        <= 1'b0;
      dep_err_reg       <= 1'b0;
      wd_ok_reg         <= 1'b0;
      wd_denied_reg     <= 1'b0;
      pin_err_reg       <= 1'b0;
      card_ejected_reg  <= (state_reg == S_EJECT);
      card_retained_reg <= (state_reg == S_RETAIN);
      show_balance_reg  <= 1'b0;
      balance_out_reg   <= '0;
      tmr_reg           <= (any_strobe || !timed) ? '0 : tmr_reg + TMR_W'(1);

      // A pulled card or an idle timeout pre-empts everything, including a
      // pending UPDATE, whose write is then abandoned.
      if (card_drop || timeout) begin
        state_reg <= S_EJECT;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (card_in) begin
              acct_reg  <= acct_id;
              state_reg <= lock_reg[acct_id] ? S_RETAIN : S_LANG;
            end
          end
          S_LANG: begin
            if (lang_valid) state_reg <= S_PIN;
          end
          S_PIN: begin
            if (pin_valid) begin
              if (pin == sel_pin) begin
                tries_reg <= '0;
                state_reg <= S_MENU;
              end else begin
                pin_err_reg <= 1'b1;
                if (tries_reg == TRY_W'(MAX_TRIES - 1)) begin
                  lock_reg[acct_reg] <= 1'b1;
                  tries_reg          <= '0;
                  state_reg          <= S_RETAIN;
                end else begin
                  tries_reg <= tries_reg + TRY_W'(1);
                end
              end
            end
          end
          S_MENU, S_SHOW: begin
            if (op_valid) begin
              case (op_code)
                2'b00: state_reg <= S_EJECT;
                2'b01: begin
                  state_reg        <= S_SHOW;
                  show_balance_reg <= 1'b1;
                  balance_out_reg  <= sel_bal;
                end
                2'b10: state_reg <= S_DEP;
                default: state_reg <= S_WD;
              endcase
            end else if (state_reg == S_SHOW) begin
              show_balance_reg <= 1'b1;
              balance_out_reg  <= balance_out_reg;
            end
          end
          S_DEP: begin
            if (amt_valid) begin
              amt_reg    <= amount;
              is_dep_reg <= 1'b1;
              if (dep_ovf) begin
                dep_err_reg <= 1'b1;
                state_reg   <= S_MENU;
              end else begin
                state_reg <= S_UPDATE;
              end
            end
          end
          S_WD: begin
            if (amt_valid) begin
              amt_reg    <= amount;
              is_dep_reg <= 1'b0;
              if (amount > sel_bal) begin
                wd_denied_reg <= 1'b1;
                state_reg     <= S_MENU;
              end else begin
                state_reg <= S_UPDATE;
              end
            end
          end
          S_UPDATE: begin
            bal_mem[acct_reg] <= upd_bal;
            dep_ok_reg        <= is_dep_reg;
            wd_ok_reg         <= !is_dep_reg;
            show_balance_reg  <= 1'b1;
            balance_out_reg   <= upd_bal;
            state_reg         <= S_SHOW;
          end
          S_EJECT, S_RETAIN: begin
            tries_reg <= '0;
            state_reg <= S_IDLE;
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  assign state         = state_reg;
  assign balance_out   = balance_out_reg;
  assign show_balance  = show_balance_reg;
  assign dep_ok        = dep_ok_reg;
  assign dep_err       = dep_err_reg;
  assign wd_ok         = wd_ok_reg;
  assign wd_denied     = wd_denied_reg;
  assign pin_err       = pin_err_reg;
  assign card_ejected  = card_ejected_reg;
  assign card_retained = card_retained_reg;

endmodule

// File: tb/tb_atm_account_ctrl.sv
// Scoreboard bench for atm_account_ctrl: a 32-bit instance driven through
// session scenarios plus an 8-bit-balance instance sharing the same stimulus.
module tb_atm_account_ctrl;

  localparam int TO = 255;
  localparam int EV_PIN_ERR = 0, EV_DEP_OK = 1, EV_DEP_ERR = 2, EV_WD_OK = 3;
  localparam int EV_WD_DENIED = 4, EV_EJECT = 5, EV_RETAIN = 6;

  typedef struct packed {
    logic [3:0]  kind;
    logic [31:0] bal;
  } ev_t;

  logic        clk, reset, card_in, lang_valid, pin_valid, op_valid, amt_valid;
  logic [1:0]  acct_id, op_code;
  logic [15:0] pin;
  logic [31:0] amount;

  logic [3:0]  state;
  logic [31:0] balance_out;
  logic show_balance, dep_ok, dep_err, wd_ok, wd_denied, pin_err, card_ejected, card_retained;

  logic [3:0]  b_state;
  logic [7:0]  b_balance_out;
  logic b_show_balance, b_dep_ok, b_dep_err, b_wd_ok, b_wd_denied, b_pin_err;
  logic b_card_ejected, b_card_retained;

  int tests = 0;
  int failures = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];
  ev_t e, o;
  logic [6:0] pulse_vec;
  ev_t mon_ev;

  atm_account_ctrl dut (
    .clk(clk), .reset(reset), .card_in(card_in), .acct_id(acct_id),
    .lang_valid(lang_valid), .pin_valid(pin_valid), .pin(pin),
    .op_valid(op_valid), .op_code(op_code), .amt_valid(amt_valid), .amount(amount),
    .state(state), .balance_out(balance_out), .show_balance(show_balance),
    .dep_ok(dep_ok), .dep_err(dep_err), .wd_ok(wd_ok), .wd_denied(wd_denied),
    .pin_err(pin_err), .card_ejected(card_ejected), .card_retained(card_retained)
  );

  atm_account_ctrl #(.BAL_W(8), .BAL_INIT(64'd250)) dut_b (
    .clk(clk), .reset(reset), .card_in(card_in), .acct_id(acct_id),
    .lang_valid(lang_valid), .pin_valid(pin_valid), .pin(pin),
    .op_valid(op_valid), .op_code(op_code), .amt_valid(amt_valid), .amount(amount[7:0]),
    .state(b_state), .balance_out(b_balance_out), .show_balance(b_show_balance),
    .dep_ok(b_dep_ok), .dep_err(b_dep_err), .wd_ok(b_wd_ok), .wd_denied(b_wd_denied),
    .pin_err(b_pin_err), .card_ejected(b_card_ejected), .card_retained(b_card_retained)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every status pulse of the main instance becomes an observed event.
  always @(negedge clk) begin
    if (!reset) begin
      pulse_vec = {card_retained, card_ejected, wd_denied, wd_ok, dep_err, dep_ok, pin_err};
      for (int k = 0; k < 7; k++) begin
        if (pulse_vec[k]) begin
          mon_ev.kind = 4'(k);
          mon_ev.bal  = (k == EV_DEP_OK || k == EV_WD_OK) ? balance_out : 32'd0;
          obs_q.push_back(mon_ev);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_ev(input int k, input logic [31:0] b);
    ev_t ev;
    ev.kind = 4'(k);
    ev.bal  = b;
    exp_q.push_back(ev);
  endtask

  task automatic insert(input logic [1:0] id);
    card_in = 1'b1; acct_id = id; step();
  endtask
  task automatic lang();
    lang_valid = 1'b1; step(); lang_valid = 1'b0;
  endtask
  task automatic enter_pin(input logic [15:0] p);
    pin_valid = 1'b1; pin = p; step(); pin_valid = 1'b0;
  endtask
  task automatic op(input logic [1:0] c);
    op_valid = 1'b1; op_code = c; step(); op_valid = 1'b0;
  endtask
  task automatic amt(input logic [31:0] a);
    amt_valid = 1'b1; amount = a; step(); amt_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; card_in = 1'b0; acct_id = 2'd0; lang_valid = 1'b0; pin_valid = 1'b0;
    pin = 16'd0; op_valid = 1'b0; op_code = 2'd0; amt_valid = 1'b0; amount = 32'd0;
    step(3);
    tests++;
    if (state !== 4'd0) begin failures++; $display("FAIL reset_state: got %0d, required 0", state); end
    tests++;
    if ({show_balance, balance_out} !== 33'd0) begin
      failures++; $display("FAIL reset_show: got show=%0b bal=%0d, required 0/0", show_balance, balance_out);
    end
    tests++;
    if ({dep_ok, dep_err, wd_ok, wd_denied, pin_err, card_ejected, card_retained} !== 7'd0) begin
      failures++; $display("FAIL reset_pulses: got %b, required 0000000",
                           {dep_ok, dep_err, wd_ok, wd_denied, pin_err, card_ejected, card_retained});
    end
    reset = 1'b0;
    op(2'b01);
    amt(32'd7);
    tests++;
    if (state !== 4'd0) begin failures++; $display("FAIL idle_ignores_strobes: got %0d, required 0", state); end
  endtask

  task automatic test_deposit();
    insert(2'd2);
    tests++;
    if (state !== 4'd1) begin failures++; $display("FAIL dep_lang: got %0d, required 1", state); end
    lang(); enter_pin(16'h000A);
    tests++;
    if (state !== 4'd3) begin failures++; $display("FAIL dep_menu: got %0d, required 3", state); end
    op(2'b10);
    push_ev(EV_DEP_OK, 32'd1000500);
    amt(32'd500);
    tests++;
    if (state !== 4'd6) begin failures++; $display("FAIL dep_update: got %0d, required 6", state); end
    step();
    tests++;
    if ({state, show_balance, balance_out} !== {4'd7, 1'b1, 32'd1000500}) begin
      failures++; $display("FAIL dep_show: got st=%0d show=%0b bal=%0d, required 7/1/1000500",
                           state, show_balance, balance_out);
    end
    push_ev(EV_EJECT, 32'd0);
    op(2'b00);
    tests++;
    if (state !== 4'd8) begin failures++; $display("FAIL dep_eject: got %0d, required 8", state); end
    card_in = 1'b0; step();
    tests++;
    if (state !== 4'd0) begin failures++; $display("FAIL dep_idle: got %0d, required 0", state); end
    step();
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      e = '1; o = '1;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      tests++;
      if (o !== e) begin failures++; $display("FAIL deposit_event: got kind=%0d bal=%0d, required kind=%0d bal=%0d", o.kind, o.bal, e.kind, e.bal); end
    end
  endtask

  task automatic test_withdraw();
    insert(2'd1); lang(); enter_pin(16'h000A); op(2'b11);
    push_ev(EV_WD_DENIED, 32'd0);
    amt(32'd1000001);
    tests++;
    if (state !== 4'd3) begin failures++; $display("FAIL wd_denied_menu: got %0d, required 3", state); end
    op(2'b01);
    tests++;
    if ({show_balance, balance_out} !== {1'b1, 32'd1000000}) begin
      failures++; $display("FAIL wd_denied_bal: got show=%0b bal=%0d, required 1/1000000", show_balance, balance_out);
    end
    op(2'b11);
    push_ev(EV_WD_OK, 32'd0);
    amt(32'd1000000);
    step();
    tests++;
    if ({state, show_balance, balance_out} !== {4'd7, 1'b1, 32'd0}) begin
      failures++; $display("FAIL wd_all_show: got st=%0d show=%0b bal=%0d, required 7/1/0",
                           state, show_balance, balance_out);
    end
    push_ev(EV_EJECT, 32'd0);
    op(2'b00); card_in = 1'b0; step(2);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      e = '1; o = '1;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      tests++;
      if (o !== e) begin failures++; $display("FAIL withdraw_event: got kind=%0d bal=%0d, required kind=%0d bal=%0d", o.kind, o.bal, e.kind, e.bal); end
    end
  endtask

  task automatic test_pin_lock();
    insert(2'd0); lang();
    for (int i = 0; i < 3; i++) begin
      push_ev(EV_PIN_ERR, 32'd0);
      enter_pin(16'h1234 + 16'(i));
    end
    tests++;
    if (state !== 4'd9) begin failures++; $display("FAIL lock_retain: got %0d, required 9", state); end
    push_ev(EV_RETAIN, 32'd0);
    card_in = 1'b0; step();
    push_ev(EV_RETAIN, 32'd0);
    insert(2'd0);
    tests++;
    if (state !== 4'd9) begin failures++; $display("FAIL lock_reinsert: got %0d, required 9", state); end
    card_in = 1'b0; step();
    insert(2'd3); lang(); enter_pin(16'h000A);
    tests++;
    if (state !== 4'd3) begin failures++; $display("FAIL lock_other_acct: got %0d, required 3", state); end
    push_ev(EV_EJECT, 32'd0);
    op(2'b00); card_in = 1'b0; step(2);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      e = '1; o = '1;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      tests++;
      if (o !== e) begin failures++; $display("FAIL pin_lock_event: got kind=%0d bal=%0d, required kind=%0d bal=%0d", o.kind, o.bal, e.kind, e.bal); end
    end
  endtask

  task automatic test_timeout();
    insert(2'd3); lang(); enter_pin(16'h000A);
    step(TO - 1);
    tests++;
    if (state !== 4'd3) begin failures++; $display("FAIL timeout_early: got %0d, required 3", state); end
    amt(32'd1);
    tests++;
    if (state !== 4'd3) begin failures++; $display("FAIL timeout_restart: got %0d, required 3", state); end
    step(TO - 1);
    tests++;
    if (state !== 4'd3) begin failures++; $display("FAIL timeout_hold: got %0d, required 3", state); end
    push_ev(EV_EJECT, 32'd0);
    step();
    tests++;
    if (state !== 4'd8) begin failures++; $display("FAIL timeout_eject: got %0d, required 8", state); end
    card_in = 1'b0; step(2);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      e = '1; o = '1;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      tests++;
      if (o !== e) begin failures++; $display("FAIL timeout_event: got kind=%0d bal=%0d, required kind=%0d bal=%0d", o.kind, o.bal, e.kind, e.bal); end
    end
  endtask

  task automatic test_card_drop();
    insert(2'd2); lang(); enter_pin(16'h000A); op(2'b10);
    card_in = 1'b0; step();
    tests++;
    if (state !== 4'd8) begin failures++; $display("FAIL drop_eject: got %0d, required 8", state); end
    push_ev(EV_EJECT, 32'd0);
    step();
    insert(2'd2); lang(); enter_pin(16'h000A); op(2'b01);
    tests++;
    if (balance_out !== 32'd1000500) begin failures++; $display("FAIL drop_balance: got %0d, required 1000500", balance_out); end
    push_ev(EV_EJECT, 32'd0);
    op(2'b00); card_in = 1'b0; step(2);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      e = '1; o = '1;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      tests++;
      if (o !== e) begin failures++; $display("FAIL card_drop_event: got kind=%0d bal=%0d, required kind=%0d bal=%0d", o.kind, o.bal, e.kind, e.bal); end
    end
  endtask

  task automatic test_reset_mid_update();
    insert(2'd2); lang(); enter_pin(16'h000A); op(2'b10); amt(32'd100);
    tests++;
    if (state !== 4'd6) begin failures++; $display("FAIL mid_update_state: got %0d, required 6", state); end
    #1 reset = 1'b1; card_in = 1'b0;
    #1;
    tests++;
    if ({state, show_balance, balance_out} !== 37'd0) begin
      failures++; $display("FAIL mid_update_async: got st=%0d show=%0b bal=%0d, required 0/0/0",
                           state, show_balance, balance_out);
    end
    step(2); reset = 1'b0;
    insert(2'd2); lang(); enter_pin(16'h000A); op(2'b01);
    tests++;
    if (balance_out !== 32'd1000000) begin failures++; $display("FAIL mid_update_lost: got %0d, required 1000000", balance_out); end
    push_ev(EV_EJECT, 32'd0);
    op(2'b00); card_in = 1'b0; step();
    insert(2'd0);
    tests++;
    if (state !== 4'd1) begin failures++; $display("FAIL reset_unlock: got %0d, required 1", state); end
    push_ev(EV_EJECT, 32'd0);
    card_in = 1'b0; step(3);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      e = '1; o = '1;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      tests++;
      if (o !== e) begin failures++; $display("FAIL mid_update_event: got kind=%0d bal=%0d, required kind=%0d bal=%0d", o.kind, o.bal, e.kind, e.bal); end
    end
  endtask

  // Narrow instance overflows where the 32-bit one does not; the two paths
  // re-converge because SHOW and MENU both take the next op strobe.
  task automatic test_narrow_overflow();
    reset = 1'b1; card_in = 1'b0; step(2); reset = 1'b0;
    insert(2'd1); lang(); enter_pin(16'h000A); op(2'b10);
    push_ev(EV_DEP_OK, 32'd1000006);
    amt(32'd6);
    tests++;
    if ({b_state, b_dep_err} !== {4'd3, 1'b1}) begin
      failures++; $display("FAIL narrow_dep_err: got st=%0d err=%0b, required 3/1", b_state, b_dep_err);
    end
    op(2'b01);
    tests++;
    if ({b_show_balance, b_balance_out} !== {1'b1, 8'd250}) begin
      failures++; $display("FAIL narrow_unchanged: got show=%0b bal=%0d, required 1/250", b_show_balance, b_balance_out);
    end
    op(2'b10);
    push_ev(EV_DEP_OK, 32'd1000011);
    amt(32'd5); step();
    tests++;
    if ({b_dep_ok, b_balance_out} !== {1'b1, 8'd255}) begin
      failures++; $display("FAIL narrow_dep_ok: got ok=%0b bal=%0d, required 1/255", b_dep_ok, b_balance_out);
    end
    push_ev(EV_EJECT, 32'd0);
    op(2'b00); card_in = 1'b0; step(2);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      e = '1; o = '1;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      tests++;
      if (o !== e) begin failures++; $display("FAIL narrow_event: got kind=%0d bal=%0d, required kind=%0d bal=%0d", o.kind, o.bal, e.kind, e.bal); end
    end
  endtask

  initial begin
    test_reset();
    test_deposit();
    test_withdraw();
    test_pin_lock();
    test_timeout();
    test_card_drop();
    test_reset_mid_update();
    test_narrow_overflow();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/atm_account_ctrl.md
ATM_ACCOUNT_CTRL -- requirements
Module: atm_account_ctrl

Interface
REQ-001 Parameter NUM_ACCT, default 4: number of accounts (>=2); AID_W = clog2(NUM_ACCT).
REQ-002 Parameter BAL_W, default 32: balance and amount width.
REQ-003 Parameter PIN_W, default 16: PIN width.
REQ-004 Parameter MAX_TRIES, default 3: wrong-PIN attempts allowed before card retention.
REQ-005 Parameter TIMEOUT_CYC, default 255: idle cycles allowed in an input-waiting state.
REQ-006 Parameters BAL_INIT, default 1000000, and PIN_INIT, default 16'h000A: reset value of every account balance and PIN.
REQ-007 clk  in  1  clock; all state changes on its rising edge.
REQ-008 reset  in  1  reset, asynchronous, active-high.
REQ-009 card_in  in  1  card present (level), sampled in IDLE.
REQ-010 acct_id  in  AID_W  account on inserted card, captured on the IDLE->LANG transition.
REQ-011 lang_valid  in  1  language selection done.
REQ-012 pin_valid / pin  in  1 / PIN_W  PIN entry strobe and value.
REQ-013 op_valid / op_code  in  1 / 2  menu strobe; 00 exit, 01 balance, 10 deposit, 11 withdraw.
REQ-014 amt_valid / amount  in  1 / BAL_W  amount strobe and value for deposit or withdraw.
REQ-015 state  out  4  current FSM state code (REQ-018 order, IDLE=0).
REQ-016 balance_out  out  BAL_W  balance of the selected account, valid while show_balance=1.
REQ-017 show_balance, dep_ok, dep_err, wd_ok, wd_denied, pin_err, card_ejected, card_retained  out  1 each  one-cycle registered status pulses, except show_balance (level).

Function
REQ-018 States: IDLE, LANG, PIN, MENU, DEP, WD, UPDATE, SHOW, EJECT, RETAIN.
REQ-019 IDLE: card_in=1 and account not locked -> LANG; card_in=1 and account locked -> RETAIN; otherwise stay.
REQ-020 LANG: lang_valid -> PIN.
REQ-021 PIN: pin_valid with a matching PIN -> MENU and try counter cleared.
REQ-022 PIN: pin_valid with a wrong PIN -> pin_err pulse and try counter incremented; on reaching MAX_TRIES -> RETAIN and account lock bit set; otherwise stay in PIN.
REQ-023 MENU, on op_valid: 00 -> EJECT; 01 -> SHOW; 10 -> DEP; 11 -> WD.
REQ-024 DEP, on amt_valid: if balance+amount fits in BAL_W bits, -> UPDATE; otherwise dep_err pulse, balance unchanged, -> MENU.
REQ-025 WD, on amt_valid: if amount <= balance, -> UPDATE; otherwise wd_denied pulse, balance unchanged, -> MENU.
REQ-026 An amount of 0 is legal: dep_ok or wd_ok pulses and the balance is unchanged.
REQ-027 UPDATE: exactly one cycle; the selected balance is written (+amount for a deposit, -amount for a withdrawal); dep_ok or wd_ok pulses in the cycle after the write; -> SHOW.
REQ-028 SHOW: show_balance=1 and balance_out holds the post-update value; next op_valid is handled exactly as in MENU (REQ-023).
REQ-029 EJECT: card_ejected pulse; -> IDLE.
REQ-030 RETAIN: card_retained pulse; -> IDLE; the lock bit stays set until reset.
REQ-031 Timeout: in LANG, PIN, MENU, DEP, WD or SHOW, a cycle counter clears on entry and on any valid strobe; reaching TIMEOUT_CYC -> EJECT.
REQ-032 The try counter also clears on EJECT and RETAIN.
REQ-033 Strobes not relevant to the current state are ignored.
REQ-034 If card_in deasserts in any state other than IDLE, EJECT, or RETAIN, the FSM goes to EJECT on the next cycle; this has priority over every other transition.
REQ-035 Amount and PIN are captured in the cycle their strobe is high; the balance compare uses the stored balance of the selected account only.

Reset
REQ-036 Reset asserted at any time, including mid-UPDATE: state=IDLE, all pulses and show_balance=0, balance_out=0, counters=0, all lock bits clear, every balance=BAL_INIT, every PIN=PIN_INIT.
REQ-037 An update interrupted by reset is lost; the balance returns to BAL_INIT.

Verification
REQ-038 Account 2: card, language, PIN 000A, deposit 500 -> dep_ok; SHOW with balance_out=1000500; then op 00 -> card_ejected, then IDLE.
REQ-039 Account 1: withdraw 1000001 -> wd_denied and balance 1000000; then withdraw 1000000 -> wd_ok and balance_out=0.
REQ-040 Account 0: three wrong PINs -> pin_err x3, then card_retained; reinsert account 0 -> RETAIN directly; account 3 still usable.
REQ-041 BAL_W=8, BAL_INIT=250: deposit 6 -> dep_err, balance 250; deposit 5 -> dep_ok, balance 255.
REQ-042 MENU with no strobe for TIMEOUT_CYC cycles -> EJECT; a strobe at cycle TIMEOUT_CYC-1 restarts the count.
REQ-043 card_in dropped in DEP -> EJECT next cycle and balance unchanged; reset during UPDATE -> IDLE with balance=BAL_INIT.
